// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Purpose : request/response data-bus bundle between the MEM-stage access
//           controller (master) and the data memory or cache (slave).
// Signals :
//   data_req      master->slave  access request, qualified by data_addr_ok
//   data_wr       master->slave  1 = store, 0 = load
//   data_size     master->slave  0 byte, 1 half, 2 word
//   data_addr     master->slave  byte address
//   data_wdata    master->slave  store data, already replicated across lanes
//   data_addr_ok  slave->master  request accepted this cycle
//   data_data_ok  slave->master  response (read data / write ack) this cycle
//   data_rdata    slave->master  raw 32-bit read word
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Purpose : MEM-stage load/store controller. It issues one bus transaction
//           per load/store instruction over a split address/data handshake,
//           stalls the pipeline until the data phase completes, and
//           aligns/extends load data into readdataM.
// Ports   :
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   memtoregM/memwriteM  load / store present in MEM
//   fcM                  access code (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
//   aluoutM              byte address
//   writedataM           right-aligned store data
//   flushM               kill the MEM instruction
//   advanceM             EX/MEM loads a new instruction at the next edge
//   bus                  data-bus master modport (mem_access_ctrl_if)
//   mem_stallM           pipeline stall request
//   readdataM            aligned and extended load result (registered)
//   adelM/adesM          load/store address error
// Build option:
//   MEM_ALIGN_CHECK_EN   when defined, misaligned half/word accesses raise
//                        adelM/adesM and are not issued; when undefined the
//                        error outputs are tied low and every access issues.
// ---------------------------------------------------------------------------
module mem_access_ctrl (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     memtoregM,
    input  logic                     memwriteM,
    input  logic [2:0]               fcM,
    input  logic [31:0]              aluoutM,
    input  logic [31:0]              writedataM,
    input  logic                     flushM,
    input  logic                     advanceM,
    mem_access_ctrl_if.master        bus,
    output logic                     mem_stallM,
    output logic [31:0]              readdataM,
    output logic                     adelM,
    output logic                     adesM
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned FW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic          cancel;
    logic          op;

    // Request fields captured when the access issues, so the bus stays
    // stable while waiting for addr_ok and the load lane is known at data_ok.
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [FW-1:0] lat_fc;
    logic          lat_wr;

    logic          req_c;
    logic          stall_c;
    logic          wr_c;
    logic [1:0]    size_c;
    logic [AW-1:0] addr_c;
    logic [DW-1:0] wdata_c;

    // Replicate right-aligned store data across every lane of its size.
    function automatic logic [DW-1:0] pack_wdata(input logic [1:0] size,
                                                 input logic [DW-1:0] wd);
        logic [DW-1:0] r;
        case (size)
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [DW-1:0] align_load(input logic [FW-1:0] fc,
                                                 input logic [1:0]    off,
                                                 input logic [DW-1:0] rd);
        logic [7:0]    b;
        logic [15:0]   h;
        logic [DW-1:0] r;
        b = 8'(rd >> {off, 3'b000});
        h = off[1] ? rd[31:16] : rd[15:0];
        case (fc[1:0])
            2'b00:   r = fc[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = fc[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Address error detection.
`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    always_comb begin
        misaligned = ((fcM[1:0] == 2'b01) && aluoutM[0]) ||
                     (fcM[1] && (aluoutM[1:0] != 2'b00));
    end
    assign adelM = memtoregM & misaligned;
    assign adesM = memwriteM & misaligned;
`else
    assign adelM = 1'b0;
    assign adesM = 1'b0;
`endif

    // A live access that may issue from IDLE.
    assign op = (memtoregM | memwriteM) & ~flushM & ~adelM & ~adesM;

    // Bus and stall outputs. IDLE reflects the pipeline inputs directly so a
    // request goes out in the same cycle the instruction reaches MEM; every
    // other state drives the fields captured at issue.
    always_comb begin
        req_c   = 1'b0;
        stall_c = 1'b0;
        wr_c    = 1'b0;
        size_c  = 2'b00;
        addr_c  = '0;
        wdata_c = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    req_c   = op;
                    stall_c = op;
                    wr_c    = memwriteM;
                    size_c  = fcM[1:0];
                    addr_c  = aluoutM;
                    wdata_c = pack_wdata(fcM[1:0], writedataM);
                end
                ADDR: begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    wr_c    = lat_wr;
                    size_c  = lat_fc[1:0];
                    addr_c  = lat_addr;
                    wdata_c = pack_wdata(lat_fc[1:0], lat_wdata);
                end
                DATA: begin
                    stall_c = 1'b1;
                    wr_c    = lat_wr;
                    size_c  = lat_fc[1:0];
                    addr_c  = lat_addr;
                    wdata_c = pack_wdata(lat_fc[1:0], lat_wdata);
                end
                DONE: begin
                    wr_c    = lat_wr;
                    size_c  = lat_fc[1:0];
                    addr_c  = lat_addr;
                    wdata_c = pack_wdata(lat_fc[1:0], lat_wdata);
                end
                default: begin
                    stall_c = 1'b0;
                end
            endcase
        end
    end

    assign bus.data_req   = req_c;
    assign bus.data_wr    = wr_c;
    assign bus.data_size  = size_c;
    assign bus.data_addr  = addr_c;
    assign bus.data_wdata = wdata_c;
    assign mem_stallM     = stall_c;

    // Transaction FSM, cancel flag, issue capture and load result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cancel    <= 1'b0;
            readdataM <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_fc    <= '0;
            lat_wr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cancel <= 1'b0;
                    if (op) begin
                        lat_addr  <= aluoutM;
                        lat_wdata <= writedataM;
                        lat_fc    <= fcM;
                        lat_wr    <= memwriteM;
                        state     <= bus.data_addr_ok ? DATA : ADDR;
                    end
                end
                ADDR: begin
                    if (flushM) begin
                        cancel <= 1'b1;
                    end
                    if (bus.data_addr_ok) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (flushM) begin
                        cancel <= 1'b1;
                    end
                    // A flush arriving with data_ok still cancels the result.
                    if (bus.data_data_ok) begin
                        if (cancel || flushM) begin
                            cancel <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            readdataM <= align_load(lat_fc, lat_addr[1:0],
                                                    bus.data_rdata);
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (advanceM) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Purpose : self-checking bench for mem_access_ctrl. Directed scenarios plus
//           randomized load/store transactions with random handshake delays,
//           checked cycle by cycle against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        memtoregM;
    logic        memwriteM;
    logic [2:0]  fcM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        flushM;
    logic        advanceM;
    logic        mem_stallM;
    logic [31:0] readdataM;
    logic        adelM;
    logic        adesM;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] exp_rd;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .memtoregM  (memtoregM),
        .memwriteM  (memwriteM),
        .fcM        (fcM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .flushM     (flushM),
        .advanceM   (advanceM),
        .bus        (bus),
        .mem_stallM (mem_stallM),
        .readdataM  (readdataM),
        .adelM      (adelM),
        .adesM      (adesM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Load result from the access rules, using plain arithmetic.
    function automatic logic [31:0] model_load(input logic [2:0] fc,
                                               input logic [31:0] addr,
                                               input logic [31:0] rd);
        int unsigned v;
        case (fc[1:0])
            2'b00: begin
                v = (rd >> (8 * addr[1:0])) & 32'hFF;
                if (!fc[2] && v >= 128) v = v + 32'hFFFFFF00;
            end
            2'b01: begin
                v = (rd >> (16 * addr[1])) & 32'hFFFF;
                if (!fc[2] && v >= 32768) v = v + 32'hFFFF0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] fc,
                                                input logic [31:0] wd);
        logic [31:0] v;
        case (fc[1:0])
            2'b00:   v = (wd & 32'hFF) * 32'h01010101;
            2'b01:   v = (wd & 32'hFFFF) * 32'h00010001;
            default: v = wd;
        endcase
        return v;
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    function automatic bit model_misaligned(input logic [2:0] fc,
                                            input logic [31:0] addr);
        return ((fc[1:0] == 2'b01) && (addr % 2 != 0)) ||
               ((fc[1:0] == 2'b10) && (addr % 4 != 0));
    endfunction
`endif

    // One cycle: inputs change 1ns after the edge, outputs are sampled later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles with no live access; a killed load in IDLE must not issue.
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            memwriteM         = 1'b0;
            memtoregM         = 1'($urandom_range(0, 1));
            flushM            = memtoregM;
            advanceM          = 1'($urandom_range(0, 1));
            bus.data_addr_ok  = 1'($urandom_range(0, 1));
            bus.data_data_ok  = 1'($urandom_range(0, 1));
            bus.data_rdata    = $urandom;
            #1;
            check({tag, "_idle_req"},   32'(bus.data_req), 32'd0);
            check({tag, "_idle_stall"}, 32'(mem_stallM),   32'd0);
            check({tag, "_idle_rd"},    readdataM,         exp_rd);
        end
    endtask

    // One complete access. a_dly = cycles addr_ok is withheld, d_dly = cycles
    // in DATA before data_ok, kill = flush pulse in the first DATA cycle,
    // hold = DONE cycles before advanceM.
    task automatic run_access(input logic st, input logic [2:0] fc,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int a_dly,
                              input int d_dly, input logic kill,
                              input int hold, input string tag);
        int stalls = 0;
        tick();
        memtoregM  = ~st;
        memwriteM  = st;
        fcM        = fc;
        aluoutM    = addr;
        writedataM = wd;
        flushM     = 1'b0;
        advanceM   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        if (model_misaligned(fc, addr)) begin
            bus.data_addr_ok = 1'b1;
            bus.data_data_ok = 1'b0;
            #1;
            check({tag, "_adel"},    32'(adelM),        32'(~st));
            check({tag, "_ades"},    32'(adesM),        32'(st));
            check({tag, "_bad_req"}, 32'(bus.data_req), 32'd0);
            check({tag, "_bad_stl"}, 32'(mem_stallM),   32'd0);
            memtoregM = 1'b0;
            memwriteM = 1'b0;
            return;
        end
`endif
        for (int i = 0; i <= a_dly; i++) begin
            if (i != 0) tick();
            bus.data_addr_ok = (i == a_dly);
            bus.data_data_ok = 1'($urandom_range(0, 1));
            bus.data_rdata   = $urandom;
            #1;
            if (mem_stallM === 1'b1) stalls++;
            check({tag, "_a_req"},   32'(bus.data_req), 32'd1);
            check({tag, "_a_stall"}, 32'(mem_stallM),   32'd1);
            check({tag, "_a_err"},   32'({adelM, adesM}), 32'd0);
            if (i == 0 || i == a_dly) begin
                check({tag, "_addr"},  bus.data_addr,        addr);
                check({tag, "_wr"},    32'(bus.data_wr),     32'(st));
                check({tag, "_size"},  32'(bus.data_size),   32'(fc[1:0]));
                check({tag, "_wdata"}, bus.data_wdata,       model_wdata(fc, wd));
            end
        end
        for (int j = 0; j <= d_dly; j++) begin
            tick();
            bus.data_addr_ok = 1'($urandom_range(0, 1));
            bus.data_data_ok = (j == d_dly);
            bus.data_rdata   = (j == d_dly) ? rd : $urandom;
            flushM           = kill && (j == 0);
            if (kill && j == 0) begin
                memtoregM = 1'b0;
                memwriteM = 1'b0;
            end
            #1;
            if (mem_stallM === 1'b1) stalls++;
            check({tag, "_d_req"},   32'(bus.data_req), 32'd0);
            check({tag, "_d_stall"}, 32'(mem_stallM),   32'd1);
        end
        check({tag, "_stall_cnt"}, 32'(stalls), 32'(a_dly + d_dly + 2));
        if (!kill) exp_rd = model_load(fc, addr, rd);
        if (kill) begin
            for (int k = 0; k < 2; k++) begin
                tick();
                flushM           = 1'b0;
                bus.data_addr_ok = 1'($urandom_range(0, 1));
                bus.data_data_ok = 1'($urandom_range(0, 1));
                #1;
                check({tag, "_k_req"},   32'(bus.data_req), 32'd0);
                check({tag, "_k_stall"}, 32'(mem_stallM),   32'd0);
                check({tag, "_k_rd"},    readdataM,         exp_rd);
            end
        end else begin
            for (int k = 0; k <= hold; k++) begin
                tick();
                advanceM         = (k == hold);
                bus.data_addr_ok = 1'($urandom_range(0, 1));
                bus.data_data_ok = 1'($urandom_range(0, 1));
                bus.data_rdata   = $urandom;
                #1;
                check({tag, "_done_req"},   32'(bus.data_req), 32'd0);
                check({tag, "_done_stall"}, 32'(mem_stallM),   32'd0);
                check({tag, "_done_rd"},    readdataM,         exp_rd);
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        memtoregM        = 1'b1;
        memwriteM        = 1'b0;
        fcM              = 3'b010;
        aluoutM          = 32'h100;
        writedataM       = '0;
        flushM           = 1'b0;
        advanceM         = 1'b0;
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hFFFF_FFFF;
        exp_rd           = '0;

        // Reset: outputs quiet even with a live load presented.
        repeat (3) tick();
        check("rst_req",   32'(bus.data_req), 32'd0);
        check("rst_stall", 32'(mem_stallM),   32'd0);
        check("rst_rd",    readdataM,         32'd0);
        tick();
        rst       = 1'b0;
        memtoregM = 1'b0;
        idle(2, "post_rst");

        // Word load, zero-latency handshake.
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, 1, "lw");
        check("lw_value", readdataM, 32'hDEADBEEF);

        // Byte/half extraction and extension.
        run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 0, 1'b0, 0, "lb");
        check("lb_value", readdataM, 32'hFFFFFF80);
        run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 0, 1'b0, 0, "lbu");
        check("lbu_value", readdataM, 32'h00000080);
        run_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 0, 0, 1'b0, 0, "lhu");
        check("lhu_value", readdataM, 32'h00008011);

        // Byte store with addr_ok withheld.
        run_access(1'b1, 3'b000, 32'h201, 32'h12345678, 32'h0, 3, 0, 1'b0, 0, "sb");

        // Flushed load, then idle with no re-issue.
        run_access(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 0, 1, 1'b1, 0, "lw_kill");
        idle(2, "after_kill");

        // Long DONE hold.
        run_access(1'b0, 3'b010, 32'h400, 32'h0, 32'h0BADC0DE, 0, 0, 1'b0, 4, "lw_hold");

        // Misaligned word load.
        run_access(1'b0, 3'b010, 32'h102, 32'h0, 32'h13579BDF, 0, 0, 1'b0, 0, "lw_mis");

        // Reset mid-transaction, then late handshakes are ignored.
        tick();
        memtoregM = 1'b1; memwriteM = 1'b0; fcM = 3'b010; aluoutM = 32'h500;
        flushM = 1'b0; advanceM = 1'b0;
        bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b0;
        #1;
        check("mid_req", 32'(bus.data_req), 32'd1);
        tick();
        bus.data_addr_ok = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        exp_rd = '0;
        check("mid_rst_rd",    readdataM,         32'd0);
        check("mid_rst_stall", 32'(mem_stallM),   32'd0);
        check("mid_rst_req",   32'(bus.data_req), 32'd0);
        tick();
        rst = 1'b0;
        memtoregM = 1'b0;
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h5A5A5A5A;
        #1;
        check("late_req",   32'(bus.data_req), 32'd0);
        check("late_stall", 32'(mem_stallM),   32'd0);
        tick();
        #1;
        check("late_rd", readdataM, 32'd0);
        bus.data_data_ok = 1'b0;

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            logic        st;
            logic [2:0]  fc;
            int unsigned pick;
            st = 1'($urandom_range(0, 1));
            if (st) begin
                pick = $urandom_range(0, 2);
                fc   = 3'(pick);
            end else begin
                pick = $urandom_range(0, 4);
                fc   = (pick < 3) ? 3'(pick) : 3'(pick + 1);
            end
            run_access(st, fc, $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)),
                       "rnd");
            idle(int'($urandom_range(0, 2)), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high. Ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-002 SHALL have memtoregM in 1, load in MEM stage; memwriteM in 1, store in MEM stage.
REQ-003 SHALL have fcM in 3, access code: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned. Stores use 000/001/010.
REQ-004 SHALL have aluoutM in 32, byte address; writedataM in 32, store data, right-aligned.
REQ-005 SHALL have flushM in 1, kill the MEM instruction; advanceM in 1, the EX/MEM register loads a new instruction at the next edge.
REQ-006 SHALL have the following bus outputs: data_req out 1; data_wr out 1; data_size out 2 (0 byte, 1 half, 2 word); data_addr out 32; data_wdata out 32.
REQ-007 SHALL have the following bus inputs: data_addr_ok in 1; data_data_ok in 1; data_rdata in 32.
REQ-008 SHALL have mem_stallM out 1, pipeline stall request; readdataM out 32, aligned and extended load result; adelM out 1, load address error; adesM out 1, store address error.

Function
REQ-009 SHALL implement FSM states IDLE, ADDR, DATA, DONE.
REQ-010 SHALL define op = (memtoregM|memwriteM) & ~flushM & ~adelM & ~adesM.
REQ-011 IDLE: SHALL drive data_req=1 and mem_stallM=1 combinationally when op=1.
REQ-012 IDLE: on op=1 with data_addr_ok=1, SHALL go to DATA. On op=1 with data_addr_ok=0, SHALL go to ADDR. On op=0, SHALL stay in IDLE with mem_stallM=0.
REQ-013 ADDR: SHALL hold data_req=1 with unchanged addr/size/wdata/wr until data_addr_ok=1, then go to DATA. mem_stallM=1.
REQ-014 DATA: SHALL drive data_req=0 and mem_stallM=1. data_data_ok SHALL be ignored in every state except DATA.
REQ-015 DATA: on data_data_ok=1, SHALL capture readdataM and go to DONE, or to IDLE if the access is cancelled.
REQ-016 DONE: SHALL drive mem_stallM=0 and data_req=0. It SHALL hold readdataM and go to IDLE on advanceM=1; otherwise it SHALL stay in DONE and issue no new request.
REQ-017 Latency: with addr_ok and data_ok each returned in their first eligible cycle, mem_stallM SHALL be high for exactly 2 cycles.
REQ-018 flushM=1 in ADDR or DATA SHALL set a cancel flag. The outstanding transaction SHALL still complete and mem_stallM SHALL stay high until data_ok. readdataM SHALL then be left unchanged. The cancel flag SHALL clear on entry to IDLE.
REQ-019 data_addr SHALL equal aluoutM unmodified. data_wr SHALL equal memwriteM. data_size SHALL equal fcM[1:0].
REQ-020 data_wdata SHALL be: byte stores replicate writedataM[7:0] x4; half stores replicate [15:0] x2; word stores pass writedataM.
REQ-021 Loads SHALL be little-endian. Lane is selected by aluoutM[1:0] (byte) or aluoutM[1] (half). fcM[2]=0 sign-extends; fcM[2]=1 zero-extends.
REQ-022 adelM/adesM SHALL be combinational and SHALL NOT create stall or bus activity.

Reset
REQ-023 rst=1 SHALL asynchronously force state IDLE, cancel=0, readdataM=0.
REQ-024 Bus outputs and mem_stallM SHALL be 0 while rst=1.
REQ-025 Reset mid-transaction SHALL abandon it. Late addr_ok/data_ok after reset SHALL be ignored.

Configuration
REQ-026 Macro MEM_ALIGN_CHECK_EN defined: adelM=memtoregM&misaligned and adesM=memwriteM&misaligned. Misaligned means a half access with addr[0]=1 or a word access with addr[1:0]!=0.
REQ-027 Macro MEM_ALIGN_CHECK_EN undefined: adelM=adesM=0. Every access SHALL issue with the address as given.

Verification
REQ-028 LW addr 0x100, addr_ok same cycle, data_ok next cycle with rdata 0xDEADBEEF -> stall 2 cycles, readdataM=0xDEADBEEF in DONE.
REQ-029 LB addr 0x103, rdata 0x80112233 -> readdataM=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x102 -> 0x00008011.
REQ-030 SB addr 0x201, writedataM 0x12345678 -> data_wdata=0x78787878, data_size=0, data_wr=1. addr_ok withheld 3 cycles -> req and addr held stable throughout.
REQ-031 LW, flushM pulsed in DATA -> transaction completes, readdataM unchanged, FSM returns to IDLE, no second request.
REQ-032 DONE with advanceM=0 for 4 cycles -> exactly one request total, mem_stallM=0 throughout DONE.
REQ-033 With MEM_ALIGN_CHECK_EN, LW addr 0x102 -> adelM=1, data_req=0, mem_stallM=0. Without the macro -> request issued with data_addr 0x102.
